// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - Issue/result bundle between the core controller and the multiply/divide unit.
interface mdu_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu.sv
// rtl/mdu.sv - Iterative radix-2 multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
module mdu #(
    parameter int WIDTH = 32
) (
    input logic  clk,
    input logic  rst,
    mdu_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    // Multiply: {partial product, multiplier}. Divide: low half shifts dividend out, quotient in.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_rem;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo_fin;
    logic [WIDTH-1:0]   w_rem_fin;

    assign w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_a_neg  = w_signed & bus.a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.b[WIDTH-1];
    // The most-negative value negates to itself, which read unsigned is exactly its magnitude.
    assign w_mag_a  = w_a_neg ? -bus.a : bus.a;
    assign w_mag_b  = w_b_neg ? -bus.b : bus.b;

    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opb : {WIDTH{1'b0}})};
    assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};

    assign w_trial   = {r_rem, r_acc[WIDTH-1]};
    assign w_ge      = (w_trial >= {1'b0, r_opb});
    assign w_rem_nxt = w_ge ? WIDTH'(w_trial - {1'b0, r_opb}) : w_trial[WIDTH-1:0];
    assign w_quo_nxt = {r_acc[WIDTH-2:0], w_ge};

    // A zero divisor leaves the remainder equal to |a|, so the dividend-sign fixup restores a.
    assign w_prod    = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    assign w_quo_fin = r_div0 ? {WIDTH{1'b1}} : (r_neg_q ? -w_quo_nxt : w_quo_nxt);
    assign w_rem_fin = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_rem    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (!bus.op[2]) begin
                            r_is_div <= bus.op[1];
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_div0   <= (bus.b == '0);
                            r_acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? w_mag_a : w_mag_b)};
                            r_opb    <= bus.op[1] ? w_mag_b : w_mag_a;
                            r_rem    <= '0;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_RUN;
                        end else if (bus.op == OP_MTHI) begin
                            r_hi <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            r_lo <= bus.a;
                        end
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        r_acc[WIDTH-1:0] <= w_quo_nxt;
                        r_rem            <= w_rem_nxt;
                    end else begin
                        r_acc <= w_acc_nxt;
                    end
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fin;
                            r_lo <= w_quo_fin;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - Directed-vector bench for mdu at WIDTH=32 and WIDTH=8.
module tb_mdu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_if #(.WIDTH(32)) bus32 ();
    mdu_if #(.WIDTH(8))  bus8 ();

    mdu #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
    mdu #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op on the 32-bit unit and follow it to done; optionally poke an MTHI mid-run.
    task automatic op32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit chained, input int poke_at,
                        output int busy_cyc, output bit got_done, output bit hi_one);
        if (!chained) @(negedge clk);
        bus32.start = 1'b1; bus32.op = op; bus32.a = a; bus32.b = b;
        @(negedge clk);
        bus32.start = 1'b0;
        busy_cyc = 0; got_done = 1'b0; hi_one = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus32.done) begin
                got_done = 1'b1;
                break;
            end
            if (bus32.busy) busy_cyc++;
            if (bus32.busy && bus32.hi == 32'h1) hi_one = 1'b1;
            if (busy_cyc == poke_at) begin
                bus32.start = 1'b1; bus32.op = 3'd4; bus32.a = 32'h1;
            end
            @(negedge clk);
            bus32.start = 1'b0;
        end
    endtask

    task automatic run32(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int c; bit g; bit h;
        op32(op, a, b, 1'b0, -1, c, g, h);
        chk({tag, "_done"}, 64'(g), 64'd1);
        chk({tag, "_busy"}, 64'(c), 64'd32);
        chk({tag, "_hi"}, 64'(bus32.hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(bus32.lo), 64'(exp_lo));
    endtask

    task automatic run8(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_hi, input logic [7:0] exp_lo);
        int c; bit g;
        @(negedge clk);
        bus8.start = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b;
        @(negedge clk);
        bus8.start = 1'b0;
        c = 0; g = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus8.done) begin
                g = 1'b1;
                break;
            end
            if (bus8.busy) c++;
            @(negedge clk);
        end
        chk({tag, "_done"}, 64'(g), 64'd1);
        chk({tag, "_busy"}, 64'(c), 64'd8);
        chk({tag, "_hi"}, 64'(bus8.hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(bus8.lo), 64'(exp_lo));
    endtask

    initial begin
        int  c;
        bit  g;
        bit  h;
        bit  seen;

        bus32.start = 1'b0; bus32.op = 3'd0; bus32.a = '0; bus32.b = '0;
        bus8.start  = 1'b0; bus8.op  = 3'd0; bus8.a  = '0; bus8.b  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_hi",   64'(bus32.hi),   64'd0);
        chk("rst_lo",   64'(bus32.lo),   64'd0);
        chk("rst_busy", 64'(bus32.busy), 64'd0);
        chk("rst_done", 64'(bus32.done), 64'd0);
        rst = 1'b0;

        run32("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        @(negedge clk);
        chk("multu_pulse", 64'(bus32.done), 64'd0);
        run32("mult_neg",  3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        run32("div_negn",  3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run32("divu_7_2",  3'd3, 32'd7,        32'd2,        32'd1,        32'd3);
        run32("div_negd",  3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
        run32("div_zero",  3'd2, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF);
        run32("div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
        run32("divu_big",  3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);

        op32(3'd1, 32'd3, 32'd4, 1'b0, 5, c, g, h);
        chk("midrun_hi1", 64'(h), 64'd0);
        chk("midrun_lo",  64'(bus32.lo), 64'd12);

        op32(3'd3, 32'd100, 32'd7, 1'b0, -1, c, g, h);
        chk("b2b_a_lo", 64'(bus32.lo), 64'd14);
        chk("b2b_a_hi", 64'(bus32.hi), 64'd2);
        op32(3'd1, 32'd6, 32'd7, 1'b1, -1, c, g, h);
        chk("b2b_b_done", 64'(g), 64'd1);
        chk("b2b_b_busy", 64'(c), 64'd32);
        chk("b2b_b_lo",   64'(bus32.lo), 64'd42);

        @(negedge clk);
        bus32.start = 1'b1; bus32.op = 3'd4; bus32.a = 32'hDEADBEEF;
        @(negedge clk);
        seen = bus32.busy | bus32.done;
        chk("mthi_hi", 64'(bus32.hi), 64'hDEADBEEF);
        chk("mthi_lo", 64'(bus32.lo), 64'd42);
        bus32.op = 3'd5; bus32.a = 32'h0BADF00D;
        @(negedge clk);
        seen |= bus32.busy | bus32.done;
        chk("mtlo_lo", 64'(bus32.lo), 64'h0BADF00D);
        chk("mtlo_hi", 64'(bus32.hi), 64'hDEADBEEF);
        bus32.op = 3'd6; bus32.a = 32'h1; bus32.b = 32'h1;
        @(negedge clk);
        bus32.start = 1'b0;
        seen |= bus32.busy | bus32.done;
        @(negedge clk);
        seen |= bus32.busy | bus32.done;
        chk("nop_hi", 64'(bus32.hi), 64'hDEADBEEF);
        chk("nop_lo", 64'(bus32.lo), 64'h0BADF00D);
        chk("mtx_no_busy_done", 64'(seen), 64'd0);

        bus32.start = 1'b1; bus32.op = 3'd1; bus32.a = 32'd5; bus32.b = 32'd6;
        @(negedge clk);
        bus32.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("rst_run_busy_pre", 64'(bus32.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_run_busy", 64'(bus32.busy), 64'd0);
        chk("rst_run_hi",   64'(bus32.hi),   64'd0);
        chk("rst_run_lo",   64'(bus32.lo),   64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= bus32.done;
        end
        chk("rst_run_nodone", 64'(seen), 64'd0);

        run8("w8_mult", 3'd0, 8'h80, 8'h80, 8'h40, 8'h00);
        run8("w8_div",  3'd2, 8'h81, 8'h04, 8'hFD, 8'hE1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers for the multi-cycle MIPS core.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU: operands come from the GPR read ports, and hi/lo feed the GPR write-data mux for MFHI/MFLO.
- Controller issues via start/op and stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (even, >= 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      synchronous, active-high reset
- start  input   1      issue request, sampled on rising edge
- op     input   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
- a      input   WIDTH  operand A (rs): multiplicand, dividend, or MTHI/MTLO source
- b      input   WIDTH  operand B (rt): multiplier or divisor
- busy   output  1      iterative operation in progress
- done   output  1      one-cycle pulse, hi/lo just updated by MULT/DIV
- hi     output  WIDTH  HI register: product upper half, or remainder
- lo     output  WIDTH  LO register: product lower half, or quotient

Behaviour:

Clock and reset
- Single clock.
- rst is synchronous and active-high; it overrides everything else.
- On reset: hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0, shadow regs=0.
- Reset during RUN abandons the operation: no done pulse, hi/lo=0.

FSM states: IDLE, RUN.

IDLE
- If start=1 and op is 0-3: latch the operand magnitudes and the sign flags (signed ops only), clear counter, go to RUN. busy=1 from the next cycle.
- If start=1 and op=4: hi<=a at this edge. lo unchanged, busy stays 0, no done.
- If start=1 and op=5: lo<=a at this edge. hi unchanged, busy stays 0, no done.
- If start=1 and op is 6-7, or start=0: no change.

RUN
- One radix-2 step per cycle for exactly WIDTH cycles (busy=1 for WIDTH cycles).
- Multiply: shift-add on a 2*WIDTH internal accumulator.
- Divide: restoring, one quotient bit per cycle, on a WIDTH+1-bit partial remainder.
- start is ignored while busy=1; the controller must hold the op.
- hi/lo are not modified during RUN. All work is done in internal shadow registers.
- On the edge ending the WIDTH-th busy cycle: apply sign correction, write hi/lo, busy<=0, done<=1, go to IDLE.
- done is high for exactly one cycle, coincident with busy=0 and the new hi/lo. A start in that cycle is accepted.
- Latency: start edge k → hi/lo valid and done=1 after edge k+WIDTH.

Arithmetic rules
- Signed ops operate on magnitudes.
- Product is negated if the operand signs differ.
- Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend. Truncation is toward zero.
- Magnitude of the most-negative value is 2^(WIDTH-1), handled unsigned; no overflow inside the datapath.
- Divide by zero (b=0, signed or unsigned): hi=a unchanged, lo=all ones. Still takes WIDTH cycles and pulses done.
- Signed most-negative / -1: lo=most-negative (wraps), hi=0.
- Unsigned ops: no sign handling.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF → busy high for 32 cycles; then hi=0xFFFFFFFE, lo=0x00000001, done pulses once. MULT a=0xFFFFFFFD (-3) b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 → lo=3, hi=1. DIV a=7 b=0xFFFFFFFE → lo=0xFFFFFFFD, hi=1.
- Boundaries:
  - DIV a=0x12345678 b=0 → hi=0x12345678, lo=0xFFFFFFFF, done after 32 cycles.
  - DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU a=0x80000000 b=0xFFFFFFFF → lo=0, hi=0x80000000.
- Handshake and reset:
  - Second start (MTHI 0x1) issued mid-RUN is ignored; hi is not 0x1.
  - Back-to-back: start in the done cycle begins a new op with 32 busy cycles.
  - rst asserted at busy cycle 10 → busy=0, hi=lo=0 the next cycle, no done ever.
- MTHI a=0xDEADBEEF, then MTLO a=0x0BADF00D on consecutive cycles → hi/lo update one edge after each; busy and done never assert. op=6 with start → no state change.
- WIDTH=8 regression:
  - MULT a=0x80 b=0x80 → hi=0x40, lo=0x00.
  - DIV a=0x81 (-127) b=0x04 → lo=0xE1 (-31), hi=0xFD (-3).
  - Done after 8 cycles.
